command_parser: RTL and testbench

//  Upstream stage of Processing_Unit. Consumes an ASCII byte stream
//  (UART RX / keypad) of the form "<A><op><B>=" and assembles decimal

---
 rtl/command_parser_if.sv | 20 ++
 rtl/command_parser.sv | 101 ++++++++++
 tb/tb_command_parser.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/command_parser_if.sv
// command_parser_if: ASCII byte stream in, held operand/operator command out
interface command_parser_if #(parameter int DATA_W = 8);
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [7:0] operation;
  logic cmd_valid;
  logic cmd_ready;
  logic error;
  modport master (
    output in_data, in_valid, cmd_ready,
    input in_ready, data_a, data_b, operation, cmd_valid, error
  );
  modport slave (
    input in_data, in_valid, cmd_ready,
    output in_ready, data_a, data_b, operation, cmd_valid, error
  );
endinterface

// File: rtl/command_parser.sv
// command_parser: parses "<A><op><B>=" ASCII into one held command; PARSER_DIVZERO_CHECK_EN rejects '/' by zero
module command_parser #(
  parameter int DATA_W = 8,
  parameter int MAX_DIGITS = 3
) (
  input logic clock,
  input logic reset,
  command_parser_if.slave bus
);
  localparam int AW = DATA_W + 4;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  typedef enum logic [2:0] {IDLE, OPA, OPB0, OPB, ISSUE, ERR} state_t;
  state_t state, state_n;
  logic [AW-1:0] acc, acc_n, acc_x;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] op_q, op_n, opr_q, opr_n;
  logic [DATA_W-1:0] a_q, a_n, b_q, b_n;
  logic take, is_dig, is_op, is_clr, is_sp, is_eq, ovf, full, dz;
  assign bus.cmd_valid = state == ISSUE;
  assign bus.error = state == ERR;
  assign bus.in_ready = ~bus.cmd_valid;
  assign bus.data_a = a_q;
  assign bus.data_b = b_q;
  assign bus.operation = opr_q;
  assign take = bus.in_valid & bus.in_ready;
  assign is_dig = bus.in_data >= 8'h30 && bus.in_data <= 8'h39;
  assign is_op = bus.in_data inside {8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h26, 8'h7C};
  assign is_clr = bus.in_data == 8'h43 || bus.in_data == 8'h63;
  assign is_sp = bus.in_data == 8'h20;
  assign is_eq = bus.in_data == 8'h3D;
  // acc is 4 bits wider than an operand so acc*10+9 never wraps before the range check
  assign acc_x = acc * AW'(10) + AW'(bus.in_data[3:0]);
  assign ovf = |acc_x[AW-1:DATA_W];
  assign full = cnt == CW'(MAX_DIGITS);
`ifdef PARSER_DIVZERO_CHECK_EN
  assign dz = op_q == 8'h2F && acc == '0;
`else
  assign dz = 1'b0;
`endif
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    op_n = op_q;
    opr_n = opr_q;
    a_n = a_q;
    b_n = b_q;
    if (state == ISSUE) begin
      if (bus.cmd_ready) state_n = IDLE;
    end else if (take && is_clr) begin
      state_n = IDLE;
      acc_n = '0;
      cnt_n = '0;
    end else if (take && state != ERR && !is_sp) begin
      case (state)
        IDLE, OPB0: begin
          state_n = !is_dig ? ERR : state == IDLE ? OPA : OPB;
          acc_n = AW'(bus.in_data[3:0]);
          cnt_n = CW'(1);
        end
        OPA, OPB: begin
          if (is_dig) begin
            state_n = (ovf || full) ? ERR : state;
            acc_n = acc_x;
            cnt_n = cnt + CW'(1);
          end else if (state == OPA && is_op) begin
            state_n = OPB0;
            a_n = acc[DATA_W-1:0];
            op_n = bus.in_data;
          end else if (state == OPB && is_eq && !dz) begin
            state_n = ISSUE;
            b_n = acc[DATA_W-1:0];
            opr_n = op_q;
          end else begin
            state_n = ERR;
          end
        end
        default: state_n = ERR;
      endcase
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      op_q <= '0;
      opr_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      op_q <= op_n;
      opr_q <= opr_n;
      a_q <= a_n;
      b_q <= b_n;
    end
  end
endmodule

// File: tb/tb_command_parser.sv
// tb_command_parser: vector table, hand-written corner sequences and random strings vs a string-level model
module tb_command_parser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  command_parser_if #(.DATA_W(8)) bus ();
  command_parser #(.DATA_W(8), .MAX_DIGITS(3)) dut (.clock(clk), .reset(rst_n), .bus(bus.slave));
  int checks = 0;
  int errors = 0;
  typedef struct {
    string s;
    bit issue;
    int a;
    int b;
    int op;
  } vec_t;
  vec_t vecs[$];
  function automatic vec_t mk(string s, bit issue, int a, int b, int op);
    vec_t v;
    v.s = s;
    v.issue = issue;
    v.a = a;
    v.b = b;
    v.op = op;
    return v;
  endfunction
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask
  task automatic put(logic [7:0] ch);
    int n = 0;
    @(negedge clk);
    bus.in_data = ch;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("in_ready timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic send(string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask
  task automatic retire(string name);
    @(negedge clk);
    bus.cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_ready = 1'b0;
    chk({name, " retire"}, bus.cmd_valid, 0);
  endtask
  task automatic run(string name, string s, bit issue, int a, int b, int op);
    put(8'h43);
    chk({name, " clear"}, bus.error, 0);
    send(s);
    chk({name, " cmd_valid"}, bus.cmd_valid, issue);
    chk({name, " error"}, bus.error, !issue);
    if (issue) begin
      chk({name, " data_a"}, bus.data_a, a);
      chk({name, " data_b"}, bus.data_b, b);
      chk({name, " operation"}, bus.operation, op);
      retire(name);
    end
  endtask
  // strip spaces, split into digits/op/digits/'=', then apply the range and length rules
  function automatic void model(string s, output bit ok, output int a, output int b, output int op);
    string t = "";
    int i = 0;
    int na = 0;
    int nb = 0;
    byte opc;
    ok = 1'b0;
    a = 0;
    b = 0;
    op = 0;
    for (int j = 0; j < s.len(); j++) if (s[j] != 8'h20) t = $sformatf("%s%c", t, s[j]);
    while (i < t.len() && t[i] >= 8'h30 && t[i] <= 8'h39) begin
      a = a * 10 + (t[i] - 8'h30);
      na++;
      i++;
    end
    if (i >= t.len()) return;
    opc = t[i];
    op = opc;
    i++;
    while (i < t.len() && t[i] >= 8'h30 && t[i] <= 8'h39) begin
      b = b * 10 + (t[i] - 8'h30);
      nb++;
      i++;
    end
    ok = na >= 1 && na <= 3 && a <= 255 && (opc inside {8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h26, 8'h7C})
      && nb >= 1 && nb <= 3 && b <= 255 && i == t.len() - 1 && t[i] == 8'h3D;
`ifdef PARSER_DIVZERO_CHECK_EN
    if (opc == 8'h2F && b == 0) ok = 1'b0;
`endif
  endfunction
  function automatic string num(int v);
    string r = $sformatf("%0d", v);
    if ($urandom_range(0, 3) == 0) r = {"0", r};
    if ($urandom_range(0, 15) == 0) r = "";
    return r;
  endfunction
  function automatic string sp();
    return $urandom_range(0, 3) == 0 ? " " : "";
  endfunction
  initial begin
    string ops = "+-*/&|x=#";
    bit ok;
    int ea, eb, eop;
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    bus.cmd_ready = 1'b0;
    vecs.push_back(mk("12+34=", 1, 12, 34, 8'h2B));
    vecs.push_back(mk("0+0=", 1, 0, 0, 8'h2B));
    vecs.push_back(mk("000+255=", 1, 0, 255, 8'h2B));
    vecs.push_back(mk("255|255=", 1, 255, 255, 8'h7C));
    vecs.push_back(mk("100/7=", 1, 100, 7, 8'h2F));
    vecs.push_back(mk("8&5=", 1, 8, 5, 8'h26));
    vecs.push_back(mk("3-1=", 1, 3, 1, 8'h2D));
    vecs.push_back(mk("256+5=", 0, 0, 0, 0));
    vecs.push_back(mk("+5=", 0, 0, 0, 0));
    vecs.push_back(mk("1234+1=", 0, 0, 0, 0));
    vecs.push_back(mk("7+=", 0, 0, 0, 0));
    vecs.push_back(mk("12+256=", 0, 0, 0, 0));
    vecs.push_back(mk("0001+1=", 0, 0, 0, 0));
    vecs.push_back(mk("5x3=", 0, 0, 0, 0));
`ifdef PARSER_DIVZERO_CHECK_EN
    vecs.push_back(mk("9/0=", 0, 0, 0, 0));
`else
    vecs.push_back(mk("9/0=", 1, 9, 0, 8'h2F));
`endif
    #12;
    chk("reset cmd_valid", bus.cmd_valid, 0);
    chk("reset error", bus.error, 0);
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset data_a", bus.data_a, 0);
    chk("reset operation", bus.operation, 0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) run($sformatf("vec%0d", i), vecs[i].s, vecs[i].issue, vecs[i].a, vecs[i].b, vecs[i].op);
    put(8'h43);
    send("25");
    chk("ovf before 3rd digit", bus.error, 0);
    put(8'h36);
    chk("ovf at 3rd digit", bus.error, 1);
    put(8'h2B);
    chk("error sticky", bus.error, 1);
    put(8'h63);
    chk("lower c clears", bus.error, 0);
    send("3-1=");
    chk("after clear valid", bus.cmd_valid, 1);
    chk("after clear a", bus.data_a, 3);
    chk("after clear b", bus.data_b, 1);
    chk("after clear op", bus.operation, 8'h2D);
    retire("after clear");
    send("255*2=");
    bus.in_data = 8'h37;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold valid", bus.cmd_valid, 1);
      chk("hold a", bus.data_a, 255);
      chk("hold b", bus.data_b, 2);
      chk("hold op", bus.operation, 8'h2A);
      chk("hold in_ready", bus.in_ready, 0);
    end
    @(negedge clk);
    bus.cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_ready = 1'b0;
    chk("hold retire", bus.cmd_valid, 0);
    chk("hold ready back", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    send("+1=");
    chk("waiting byte valid", bus.cmd_valid, 1);
    chk("waiting byte a", bus.data_a, 7);
    chk("waiting byte b", bus.data_b, 1);
    retire("waiting byte");
    put(8'h43);
    chk("clear keeps a", bus.data_a, 7);
    chk("clear keeps op", bus.operation, 8'h2B);
    send("45&");
    chk("pre-reset a", bus.data_a, 45);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset a", bus.data_a, 0);
    chk("async reset b", bus.data_b, 0);
    chk("async reset op", bus.operation, 0);
    chk("async reset valid", bus.cmd_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run("spaces", " 6 | 3 =", 1, 6, 3, 8'h7C);
    for (int k = 0; k < 60; k++) begin
      string s;
      int a = $urandom_range(0, 280);
      int b = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 280);
      byte opc = ops[$urandom_range(0, 8)];
      s = {sp(), num(a), sp(), $sformatf("%c", opc), sp(), num(b), sp(), "="};
      model(s, ok, ea, eb, eop);
      run($sformatf("rnd%0d '%s'", k, s), s, ok, ea, eb, eop);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
